// File: rtl/fifo_spi_pkg.sv
// Shared types and constants for the scope FIFO SPI read-side drain.
package fifo_spi_pkg;

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, DONE} state_t;

  localparam int unsigned STATUS_W       = 8;
  localparam int unsigned SCK_MIN_PERIOD = 8;
  localparam int unsigned CS_SETUP_MIN   = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall pulses
// in the clk domain.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   delayed;
  logic                   sync_lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain   <= {SYNC_STAGES{RESET_VAL}};
      delayed <= RESET_VAL;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], async_in};
      delayed <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = chain[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~delayed;
  assign fall     = ~sync_lvl & delayed;

endmodule

// File: rtl/fifo_spi_reader.sv
// SPI slave (mode 0, MSB first) that pops one FIFO word per chip-select frame.
// Optional status-byte prefix enabled by defining FIFO_SPI_STATUS_EN.
module fifo_spi_reader
  import fifo_spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] EMPTY_CODE  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              rdPi,
  input  logic              sck,
  input  logic              cs_n,
  output logic              miso,
  output logic              busy,
  output logic              xfer_done,
  output logic              underrun
);

`ifdef FIFO_SPI_STATUS_EN
  localparam int unsigned FRAME_W = DATA_W + STATUS_W;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  // Each sck phase must outlast the edge detector, and the MSB must be ready
  // before the first legal sck rise.
  if (SYNC_STAGES < 2 || SYNC_STAGES + 3 > CS_SETUP_MIN || SCK_MIN_PERIOD < 4) begin : g_bad_cfg
    $error("fifo_spi_reader: SYNC_STAGES incompatible with SPI timing limits");
  end

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic               sck_rise, sck_fall, cs_rise, cs_fall;
  logic [FRAME_W-1:0] pop_word, empty_word, load_word;

`ifdef FIFO_SPI_STATUS_EN
  logic [STATUS_W-1:0] status;
  // rdPi high in POP records that the FIFO was non-empty at frame start;
  // underrun still holds its pre-frame value here.
  assign status     = {~rdPi, fifo_full, underrun, {(STATUS_W-3){1'b0}}};
  assign pop_word   = {status, {DATA_W{1'b0}}};
  assign empty_word = {status, EMPTY_CODE};
  assign load_word  = {shreg[FRAME_W-1 -: STATUS_W], fifo_data};
`else
  logic unused_full;
  assign unused_full = fifo_full;
  assign pop_word    = '0;
  assign empty_word  = EMPTY_CODE;
  assign load_word   = fifo_data;
`endif

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(cs_n),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      rdPi      <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rdPi      <= 1'b0;
      xfer_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall && !cs_rise) begin
            state <= POP;
            busy  <= 1'b1;
            cnt   <= '0;
            // Pop strobe is live for the single POP cycle.
            rdPi  <= ~fifo_empty;
          end
        end
        POP: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else if (rdPi) begin
            shreg <= pop_word;
            state <= LOAD;
          end else begin
            shreg    <= empty_word;
            miso     <= empty_word[FRAME_W-1];
            underrun <= 1'b1;
            state    <= SHIFT;
          end
        end
        LOAD: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else begin
            shreg <= load_word;
            miso  <= load_word[FRAME_W-1];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else begin
            if (sck_rise) begin
              cnt <= cnt + 1'b1;
              if (cnt == LAST_BIT) state <= DONE;
            end
            if (sck_fall) begin
              shreg <= {shreg[FRAME_W-2:0], 1'b0};
              miso  <= shreg[FRAME_W-2];
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso      <= 1'b0;
            xfer_done <= 1'b1;
          end else if (sck_fall) begin
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            miso  <= shreg[FRAME_W-2];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_spi_reader.sv
// Directed bench for fifo_spi_reader: behavioural SPI master plus a registered-output
// FIFO model. Status-byte case runs only when FIFO_SPI_STATUS_EN is defined.
module tb_fifo_spi_reader;

`ifdef FIFO_SPI_STATUS_EN
  localparam int FRAME_W = 24;
  localparam logic FIRST_BIT = 1'b0;
`else
  localparam int FRAME_W = 16;
  localparam logic FIRST_BIT = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset, sck, cs_n;
  logic [15:0] fifo_data = 16'h0000;
  logic        fifo_empty, fifo_full;
  logic        rdPi, miso, busy, xfer_done, underrun;

  logic [15:0] q[$];
  int          fifo_cnt = 0;
  int          rd_pulses = 0;
  int          done_pulses = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] cap;
  logic        m_pre, m_lat, b_mid;

  assign fifo_empty = (fifo_cnt == 0);
  assign fifo_full  = (fifo_cnt >= 4);

  always #5 clk = ~clk;

  fifo_spi_reader dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .rdPi      (rdPi),
    .sck       (sck),
    .cs_n      (cs_n),
    .miso      (miso),
    .busy      (busy),
    .xfer_done (xfer_done),
    .underrun  (underrun)
  );

  // Registered-output FIFO: data for a pop appears on the cycle after rdPi.
  always @(posedge clk) begin
    if (rdPi) begin
      rd_pulses++;
      if (q.size() > 0) fifo_data <= q.pop_front();
    end
    if (xfer_done) done_pulses++;
    fifo_cnt <= q.size();
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    q.push_back(w);
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_pre = miso;
    @(posedge clk);
    #1 m_lat = miso;
    b_mid = busy;
    repeat (5) @(negedge clk);
  endtask

  task automatic sck_bit();
    sck = 1'b1;
    cap = {cap[30:0], miso};
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end(input int gap);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input int nbits, input int gap);
    cap = '0;
    cs_start();
    for (int i = 0; i < nbits; i++) sck_bit();
    cs_end(gap);
  endtask

  initial begin
    reset = 1'b0;
    sck   = 1'b0;
    cs_n  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, rdPi, miso, busy, xfer_done, underrun}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single read
    push(16'hA5C3);
    rd_pulses = 0; done_pulses = 0;
    frame(FRAME_W, 8);
    check("single_miso_before_lat", {31'd0, m_pre}, 32'd0);
    check("single_miso_at_lat", {31'd0, m_lat}, {31'd0, FIRST_BIT});
    check("single_busy_mid", {31'd0, b_mid}, 32'd1);
    check("single_data", {16'd0, cap[15:0]}, 32'h0000A5C3);
    check("single_rd", rd_pulses, 32'd1);
    check("single_done", done_pulses, 32'd1);
    check("single_underrun", {31'd0, underrun}, 32'd0);
    check("single_busy_after", {31'd0, busy}, 32'd0);

    // Empty read, then a valid frame keeps underrun sticky
    rd_pulses = 0;
    frame(FRAME_W, 8);
    check("empty_data", {16'd0, cap[15:0]}, 32'h0000FFFF);
    check("empty_rd", rd_pulses, 32'd0);
    check("empty_underrun", {31'd0, underrun}, 32'd1);
    push(16'h0001);
    frame(FRAME_W, 8);
    check("after_empty_data", {16'd0, cap[15:0]}, 32'h00000001);
    check("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Back-to-back frames
    push(16'h1234); push(16'h5678); push(16'h9ABC);
    rd_pulses = 0;
    frame(FRAME_W, 4);
    check("b2b_word0", {16'd0, cap[15:0]}, 32'h00001234);
    frame(FRAME_W, 4);
    check("b2b_word1", {16'd0, cap[15:0]}, 32'h00005678);
    frame(FRAME_W, 4);
    check("b2b_word2", {16'd0, cap[15:0]}, 32'h00009ABC);
    repeat (8) @(negedge clk);
    check("b2b_rd", rd_pulses, 32'd3);
    check("b2b_empty", {31'd0, fifo_empty}, 32'd1);

    // Abort after 7 sck rises
    push(16'hBEEF); push(16'hCAFE);
    rd_pulses = 0; done_pulses = 0;
`ifdef FIFO_SPI_STATUS_EN
    frame(15, 8);
    check("abort_partial", {25'd0, cap[6:0]}, 32'h0000005F);
`else
    frame(7, 8);
    check("abort_partial", {25'd0, cap[6:0]}, 32'h0000005F);
`endif
    check("abort_no_done", done_pulses, 32'd0);
    frame(FRAME_W, 8);
    check("abort_next_word", {16'd0, cap[15:0]}, 32'h0000CAFE);
    check("abort_rd", rd_pulses, 32'd2);
    check("abort_done_next", done_pulses, 32'd1);

    // Reset during bit 9 of the data word
    push(16'h13D7);
    cap = '0;
    cs_start();
    for (int i = 0; i < FRAME_W - 8; i++) sck_bit();
    sck = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_miso", {29'd0, miso, busy, underrun}, 32'd7);
    reset = 1'b0;
    #1;
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    push(16'h2468);
    rd_pulses = 0; done_pulses = 0;
    frame(FRAME_W, 8);
    check("post_rst_data", {16'd0, cap[15:0]}, 32'h00002468);
    check("post_rst_rd_done", {rd_pulses[15:0], done_pulses[15:0]}, 32'h00010001);

`ifdef FIFO_SPI_STATUS_EN
    push(16'h00FF); push(16'h0002); push(16'h0003); push(16'h0004);
    frame(FRAME_W, 8);
    check("status_frame", {8'd0, cap[23:0]}, 32'h004000FF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_spi_reader.md
Name: fifo_spi_reader

Overview:
- Read-side drain for the scope capture FIFO.
- The Raspberry Pi is the SPI master (mode 0, MSB first). On each chip-select frame, this block pops one 16-bit sample from sync_fifo and shifts it out on MISO.
- It drives the FIFO read strobe rdPi, which is the counterpart of the trigger block's write strobe.
- All SPI pins are sampled synchronously into the clk domain. No logic is clocked by sck.

Parameters:
- DATA_W, 16, sample width and frame length in bits.
- SYNC_STAGES, 2, flip-flop stages in the synchronizers for sck and cs_n (minimum 2).
- EMPTY_CODE, 16'hFFFF, word shifted out when the FIFO is empty at frame start.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- fifo_data  input  DATA_W  sync_fifo read data; valid on the cycle after rdPi.
- fifo_empty  input  1  sync_fifo empty flag.
- fifo_full  input  1  sync_fifo full flag (used only by the optional status byte).
- rdPi  output  1  FIFO pop strobe; one-cycle pulse.
- sck  input  1  SPI clock from the Pi; asynchronous.
- cs_n  input  1  SPI chip select from the Pi; active-low, asynchronous.
- miso  output  1  SPI serial data to the Pi.
- busy  output  1  high while a frame is in progress.
- xfer_done  output  1  one-cycle pulse after the last bit of a frame.
- underrun  output  1  sticky flag: a frame started while the FIFO was empty.

Behaviour:
- Reset values: rdPi=0, miso=0, busy=0, xfer_done=0, underrun=0; state=IDLE; shift register=0; bit counter=0; synchronizer flops=1 for cs_n and 0 for sck.
- Synchronization and edge detect:
  - sck and cs_n each pass through SYNC_STAGES flops.
  - sck rise = sync & ~delayed; sck fall = ~sync & delayed; cs fall and cs rise are detected the same way.
- Interface timing the Pi must meet (verification uses these limits):
  - sck period ≥ 8 clk cycles.
  - cs_n falling to first sck rise ≥ 8 clk cycles.
  - Last sck fall to cs_n rising ≥ 4 clk cycles.
- State machine: IDLE, POP, LOAD, SHIFT, DONE.
  - IDLE: on cs fall, go to POP.
  - POP (1 cycle):
    - FIFO not empty: assert rdPi and go to LOAD.
    - FIFO empty: load EMPTY_CODE into the shift register, set underrun, go to SHIFT.
  - LOAD (1 cycle): capture fifo_data into the shift register and go to SHIFT.
  - SHIFT:
    - miso = shift register MSB.
    - Each sck rise increments the bit counter.
    - Each sck fall shifts left and fills with 0.
    - When the bit counter reaches DATA_W on an sck rise, go to DONE.
  - DONE:
    - Further sck edges shift zeros and are not counted.
    - On cs rise, pulse xfer_done and go to IDLE.
- Latency: cs fall to valid MSB on miso = SYNC_STAGES+3 clk cycles, within the 8-cycle setup limit.
- miso is 0 whenever state is IDLE or POP. No tri-state.
- busy is 1 in every state except IDLE.
- Exactly one rdPi pulse per frame, and none when the FIFO is empty.
- Abort: cs rise in POP, LOAD or SHIFT returns to IDLE with no xfer_done. A word already popped is discarded.
- cs rise and cs fall within one synchronized cycle cannot occur with legal timing; cs rise takes priority.
- underrun clears only on reset.
- Asynchronous reset mid-frame forces all reset values immediately. The Pi must restart the frame.

Optional Feature:
- Macro: FIFO_SPI_STATUS_EN.
- When defined:
  - Frames are DATA_W+8 bits.
  - An 8-bit status byte is prepended: {fifo_empty, fifo_full, underrun, 5'b0}.
  - fifo_empty and fifo_full are sampled in POP.
  - The underrun bit reflects the value before this frame's update.
  - The counter target is DATA_W+8.
- When undefined: frames are exactly DATA_W bits, with no status byte.

Decomposition:
- Package fifo_spi_pkg holds:
  - state typedef enum {IDLE, POP, LOAD, SHIFT, DONE};
  - localparam STATUS_W = 8;
  - the minimum-timing constants SCK_MIN_PERIOD = 8 and CS_SETUP_MIN = 8.
- One sub-module: spi_sync_edge. It provides a SYNC_STAGES synchronizer plus rise/fall pulse outputs and is instantiated once each for sck and cs_n.

Test Plan:
- Single read: FIFO holds 16'hA5C3, 16-clock sck frame → one rdPi pulse; Pi captures 16'hA5C3; xfer_done pulses once after cs_n rises; underrun=0.
- Empty read: fifo_empty=1, frame → no rdPi; Pi captures 16'hFFFF; underrun=1 and stays 1 over a later valid frame of 16'h0001.
- Back-to-back: FIFO holds 16'h1234, 16'h5678, 16'h9ABC; three frames separated by 4 clk → words returned in order; three rdPi pulses; FIFO empty afterward.
- Abort: cs_n rises after 7 sck rises on word 16'hBEEF → no xfer_done; next frame returns the following FIFO word, not 16'hBEEF.
- Reset mid-shift: reset=0 during bit 9 → miso, busy and underrun are 0 immediately; the next frame after reset release behaves normally.
- Status (FIFO_SPI_STATUS_EN defined): FIFO full with head 16'h00FF → 24-bit frame 8'b0100_0000 followed by 16'h00FF.
